post_adder_acc: RTL

POST_ADDER_ACC -- requirements
Module: post_adder_acc

---
 rtl/dsp_pkg.sv | 25 ++
 rtl/post_adder_core.sv | 62 ++++++
 rtl/post_adder_acc.sv | 95 +++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP post-adder definitions: operand widths, opmode field layout and mux encodings.
package dsp_pkg;

    localparam int P_W     = 48;
    localparam int M_W     = 36;
    localparam int OPM_W   = 5;
    localparam int X_LSB   = 0;
    localparam int Z_LSB   = 2;
    localparam int SUB_BIT = 4;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } z_sel_e;

endpackage

// File: rtl/post_adder_core.sv
// Combinational X/Z operand muxing and 49-bit add/subtract of the post-adder.
// POST_ADDER_OVF_EN adds the signed-overflow detect output.
module post_adder_core
    import dsp_pkg::*;
(
    input  logic [M_W-1:0]   m_in,
    input  logic [P_W-1:0]   dab_in,
    input  logic [P_W-1:0]   c_in,
    input  logic [P_W-1:0]   pcin,
    input  logic [P_W-1:0]   p_fb,
    input  logic             cin,
    input  logic [OPM_W-1:0] opmode,
    output logic [P_W:0]     res
`ifdef POST_ADDER_OVF_EN
    ,
    output logic             ovf_det
`endif
);

    x_sel_e         x_sel;
    z_sel_e         z_sel;
    logic           sub;
    logic [P_W-1:0] x_val;
    logic [P_W-1:0] z_val;

    always_comb begin
        x_sel = x_sel_e'(opmode[X_LSB +: 2]);
        z_sel = z_sel_e'(opmode[Z_LSB +: 2]);
        sub   = opmode[SUB_BIT];
        x_val = '0;
        z_val = '0;
        case (x_sel)
            X_M:     x_val = {{(P_W-M_W){m_in[M_W-1]}}, m_in};
            X_P:     x_val = p_fb;
            X_DAB:   x_val = dab_in;
            default: x_val = '0;
        endcase
        case (z_sel)
            Z_PCIN:  z_val = pcin;
            Z_P:     z_val = p_fb;
            Z_C:     z_val = c_in;
            default: z_val = '0;
        endcase
        if (sub)
            res = {1'b0, z_val} - ({1'b0, x_val} + {{P_W{1'b0}}, cin});
        else
            res = {1'b0, z_val} + {1'b0, x_val} + {{P_W{1'b0}}, cin};
    end

`ifdef POST_ADDER_OVF_EN
    // Exact signed result in 50 bits; overflow when it does not fit 48 signed bits.
    logic [P_W+1:0] ext;
    always_comb begin
        if (sub)
            ext = {{2{z_val[P_W-1]}}, z_val} - ({{2{x_val[P_W-1]}}, x_val} + {{(P_W+1){1'b0}}, cin});
        else
            ext = {{2{z_val[P_W-1]}}, z_val} + {{2{x_val[P_W-1]}}, x_val} + {{(P_W+1){1'b0}}, cin};
        ovf_det = !((ext[P_W+1] == ext[P_W]) && (ext[P_W] == ext[P_W-1]));
    end
`endif

endmodule

// File: rtl/post_adder_acc.sv
// DSP post-adder/accumulator with optional opmode, carry-in and output registers.
// Define POST_ADDER_OVF_EN to add the sticky signed-overflow flag (ovf, ovf_clr).
module post_adder_acc
    import dsp_pkg::*;
#(
    parameter int PREG       = 1,
    parameter int OPMODEREG  = 1,
    parameter int CARRYINREG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [M_W-1:0]   m_in,
    input  logic [P_W-1:0]   dab_in,
    input  logic [P_W-1:0]   c_in,
    input  logic [P_W-1:0]   pcin,
    input  logic             carry_in,
    input  logic [OPM_W-1:0] opmode,
    input  logic             cep,
    input  logic             ceopmode,
    input  logic             cecarryin,
    output logic [P_W-1:0]   p,
    output logic [P_W-1:0]   pcout,
    output logic             carryout
`ifdef POST_ADDER_OVF_EN
    ,
    input  logic             ovf_clr,
    output logic             ovf
`endif
);

    logic [OPM_W-1:0] opmode_q, opmode_use;
    logic             cin_q, cin_use;
    logic [P_W-1:0]   p_q;
    logic             co_q;
    logic [P_W:0]     res;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opmode_q <= '0;
            cin_q    <= 1'b0;
        end else begin
            if (ceopmode)  opmode_q <= opmode;
            if (cecarryin) cin_q    <= carry_in;
        end
    end

    assign opmode_use = (OPMODEREG != 0)  ? opmode_q : opmode;
    assign cin_use    = (CARRYINREG != 0) ? cin_q    : carry_in;

`ifdef POST_ADDER_OVF_EN
    logic ovf_det;
`endif

    // Feedback always comes from p_q so PREG=0 never forms a combinational loop.
    post_adder_core u_core (
        .m_in    (m_in),
        .dab_in  (dab_in),
        .c_in    (c_in),
        .pcin    (pcin),
        .p_fb    (p_q),
        .cin     (cin_use),
        .opmode  (opmode_use),
        .res     (res)
`ifdef POST_ADDER_OVF_EN
        ,
        .ovf_det (ovf_det)
`endif
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q  <= '0;
            co_q <= 1'b0;
        end else if (cep) begin
            p_q  <= res[P_W-1:0];
            co_q <= res[P_W];
        end
    end

    assign p        = (PREG != 0) ? p_q  : res[P_W-1:0];
    assign carryout = (PREG != 0) ? co_q : res[P_W];
    assign pcout    = p;

`ifdef POST_ADDER_OVF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ovf <= 1'b0;
        else if (ovf_clr)
            ovf <= 1'b0;
        else if (cep && ovf_det)
            ovf <= 1'b1;
    end
`endif

endmodule
